// File: rtl/mmr_regbank.sv
// AXI3 slave register bank: RW control registers for PL logic plus RO status words for software.
// Optional MMR_REGBANK_WSTRB_EN enables per-byte write strobes; otherwise every beat writes the full word.
module mmr_regbank #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                ID_W     = 12,
   parameter int                RW_COUNT = 16,
   parameter int                RO_COUNT = 8,
   parameter logic [ADDR_W-1:0] BASE     = '0
) (
   input  logic                         fclk0,
   input  logic                         fclk0_rst_n,
   input  logic [ID_W-1:0]              awid,
   input  logic [ADDR_W-1:0]            awaddr,
   input  logic [3:0]                   awlen,
   input  logic [1:0]                   awburst,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [ID_W-1:0]              wid,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [3:0]                   wstrb,
   input  logic                         wlast,
   input  logic                         wvalid,
   output logic                         wready,
   output logic [ID_W-1:0]              bid,
   output logic [1:0]                   bresp,
   output logic                         bvalid,
   input  logic                         bready,
   input  logic [ID_W-1:0]              arid,
   input  logic [ADDR_W-1:0]            araddr,
   input  logic [3:0]                   arlen,
   input  logic [1:0]                   arburst,
   input  logic                         arvalid,
   output logic                         arready,
   output logic [ID_W-1:0]              rid,
   output logic [DATA_W-1:0]            rdata,
   output logic [1:0]                   rresp,
   output logic                         rlast,
   output logic                         rvalid,
   input  logic                         rready,
   output logic [RW_COUNT*DATA_W-1:0]   ctrl,
   output logic [RW_COUNT-1:0]          ctrl_wstb,
   input  logic [RO_COUNT*DATA_W-1:0]   status
);

   localparam int          WA_W   = ADDR_W - 2;
   localparam int          RW_IW  = $clog2(RW_COUNT);
   localparam int          RO_IW  = $clog2(RO_COUNT);
   localparam logic [9:0]  RW_LIM = 10'(RW_COUNT);
   localparam logic [9:0]  RO_LIM = 10'(RW_COUNT + RO_COUNT);
   localparam logic [1:0]  K_RW   = 2'd0;
   localparam logic [1:0]  K_RO   = 2'd1;
   localparam logic [1:0]  K_ERR  = 2'd2;

   localparam logic [1:0]  W_IDLE = 2'd0;
   localparam logic [1:0]  W_DATA = 2'd1;
   localparam logic [1:0]  W_RESP = 2'd2;
   localparam logic [0:0]  R_IDLE = 1'b0;
   localparam logic [0:0]  R_DATA = 1'b1;

   // Word index bits above the 4 KiB page must match BASE; the page offset selects the bank slot.
   function automatic logic [1:0] decodeKind(input logic [WA_W-1:0] w);
      if (w[WA_W-1:10] != BASE[ADDR_W-1:12]) return K_ERR;
      else if (w[9:0] < RW_LIM)               return K_RW;
      else if (w[9:0] < RO_LIM)               return K_RO;
      else                                    return K_ERR;
   endfunction

   logic [DATA_W-1:0] ctrl_q [RW_COUNT];
   logic [DATA_W-1:0] statusW [RO_COUNT];
   logic [RW_COUNT-1:0] ctrl_wstb_q;
   logic readyEn_q;

   logic [1:0]      wState_q, wState_d;
   logic [ID_W-1:0] wId_q, wId_d;
   logic [WA_W-1:0] wAddr_q, wAddr_d;
   logic [3:0]      wLen_q, wLen_d, wCnt_q, wCnt_d;
   logic [1:0]      wBurst_q, wBurst_d;
   logic            wErr_q, wErr_d;
   logic [1:0]      wKind;
   logic [RW_COUNT-1:0] wrSel;
   logic [DATA_W-1:0]   wrMask;
   logic                strobeAny;

   logic [0:0]        rState_q, rState_d;
   logic [ID_W-1:0]   rId_q, rId_d;
   logic [WA_W-1:0]   rAddr_q, rAddr_d, rSrc;
   logic [3:0]        rLen_q, rLen_d, rCnt_q, rCnt_d;
   logic [1:0]        rBurst_q, rBurst_d;
   logic              rLast_q, rLast_d;
   logic [DATA_W-1:0] rData_q, rData_d;
   logic [1:0]        rResp_q, rResp_d;
   logic [1:0]        rKind;
   logic [RO_IW-1:0]  roIdx;

   logic unusedBits;
   assign unusedBits = ^{awaddr[1:0], araddr[1:0], wstrb};

   for (genvar i = 0; i < RW_COUNT; i++) begin : g_ctrl
      assign ctrl[DATA_W*i +: DATA_W] = ctrl_q[i];
   end
   for (genvar i = 0; i < RO_COUNT; i++) begin : g_status
      assign statusW[i] = status[DATA_W*i +: DATA_W];
   end

`ifdef MMR_REGBANK_WSTRB_EN
   assign wrMask    = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
   assign strobeAny = |wstrb;
`else
   assign wrMask    = '1;
   assign strobeAny = 1'b1;
`endif

   assign awready   = readyEn_q && (wState_q == W_IDLE);
   assign wready    = (wState_q == W_DATA);
   assign bvalid    = (wState_q == W_RESP);
   assign bid       = wId_q;
   assign bresp     = bvalid ? {wErr_q, 1'b0} : 2'b00;
   assign arready   = readyEn_q && (rState_q == R_IDLE);
   assign rvalid    = (rState_q == R_DATA);
   assign rid       = rId_q;
   assign rdata     = rData_q;
   assign rresp     = rResp_q;
   assign rlast     = rLast_q;
   assign ctrl_wstb = ctrl_wstb_q;

   // Write sequencing: one beat per W handshake, errors are sticky for the whole burst.
   always_comb begin
      wState_d = wState_q;
      wId_d    = wId_q;
      wAddr_d  = wAddr_q;
      wLen_d   = wLen_q;
      wCnt_d   = wCnt_q;
      wBurst_d = wBurst_q;
      wErr_d   = wErr_q;
      wKind    = decodeKind(wAddr_q);
      wrSel    = '0;
      case (wState_q)
         W_IDLE: if (awvalid && awready) begin
            wId_d    = awid;
            wAddr_d  = awaddr[ADDR_W-1:2];
            wLen_d   = awlen;
            wBurst_d = awburst;
            wCnt_d   = '0;
            wErr_d   = 1'b0;
            wState_d = W_DATA;
         end
         W_DATA: if (wvalid) begin
            if (wid != wId_q || wKind == K_ERR) wErr_d = 1'b1;
            else if (wKind == K_RW && strobeAny) wrSel[wAddr_q[RW_IW-1:0]] = 1'b1;
            if (wlast || wCnt_q == wLen_q) begin
               wState_d = W_RESP;
            end else begin
               wCnt_d  = wCnt_q + 4'd1;
               wAddr_d = wAddr_q + {{(WA_W-1){1'b0}}, wBurst_q != 2'b00};
            end
         end
         W_RESP: if (bready) wState_d = W_IDLE;
         default: wState_d = W_IDLE;
      endcase
   end

   // Read sequencing: each beat is fetched at the handshake that launches it, so the
   // registered word reflects register contents from before any same-cycle write.
   always_comb begin
      rState_d = rState_q;
      rId_d    = rId_q;
      rAddr_d  = rAddr_q;
      rLen_d   = rLen_q;
      rCnt_d   = rCnt_q;
      rBurst_d = rBurst_q;
      rLast_d  = rLast_q;
      rData_d  = rData_q;
      rResp_d  = rResp_q;
      rSrc     = rAddr_q + {{(WA_W-1){1'b0}}, rBurst_q != 2'b00};
      if (rState_q == R_IDLE) rSrc = araddr[ADDR_W-1:2];
      rKind    = decodeKind(rSrc);
      roIdx    = RO_IW'(rSrc[9:0] - RW_LIM);
      if ((rState_q == R_IDLE && arvalid && arready) ||
          (rState_q == R_DATA && rready && !rLast_q)) begin
         if (rState_q == R_IDLE) begin
            rId_d    = arid;
            rLen_d   = arlen;
            rBurst_d = arburst;
            rCnt_d   = '0;
            rLast_d  = (arlen == 4'd0);
            rState_d = R_DATA;
         end else begin
            rCnt_d  = rCnt_q + 4'd1;
            rLast_d = ((rCnt_q + 4'd1) == rLen_q);
         end
         rAddr_d = rSrc;
         rResp_d = (rKind == K_ERR) ? 2'b10 : 2'b00;
         rData_d = '0;
         if (rKind == K_RW)      rData_d = ctrl_q[rSrc[RW_IW-1:0]];
         else if (rKind == K_RO) rData_d = statusW[roIdx];
      end else if (rState_q == R_DATA && rready) begin
         rLast_d  = 1'b0;
         rState_d = R_IDLE;
      end
   end

   always_ff @(posedge fclk0 or negedge fclk0_rst_n) begin
      if (!fclk0_rst_n) begin
         readyEn_q   <= 1'b0;
         wState_q    <= W_IDLE;
         wId_q       <= '0;
         wAddr_q     <= '0;
         wLen_q      <= '0;
         wCnt_q      <= '0;
         wBurst_q    <= '0;
         wErr_q      <= 1'b0;
         rState_q    <= R_IDLE;
         rId_q       <= '0;
         rAddr_q     <= '0;
         rLen_q      <= '0;
         rCnt_q      <= '0;
         rBurst_q    <= '0;
         rLast_q     <= 1'b0;
         rData_q     <= '0;
         rResp_q     <= '0;
         ctrl_wstb_q <= '0;
         for (int i = 0; i < RW_COUNT; i++) ctrl_q[i] <= '0;
      end else begin
         readyEn_q   <= 1'b1;
         wState_q    <= wState_d;
         wId_q       <= wId_d;
         wAddr_q     <= wAddr_d;
         wLen_q      <= wLen_d;
         wCnt_q      <= wCnt_d;
         wBurst_q    <= wBurst_d;
         wErr_q      <= wErr_d;
         rState_q    <= rState_d;
         rId_q       <= rId_d;
         rAddr_q     <= rAddr_d;
         rLen_q      <= rLen_d;
         rCnt_q      <= rCnt_d;
         rBurst_q    <= rBurst_d;
         rLast_q     <= rLast_d;
         rData_q     <= rData_d;
         rResp_q     <= rResp_d;
         ctrl_wstb_q <= wrSel;
         for (int i = 0; i < RW_COUNT; i++)
            if (wrSel[i]) ctrl_q[i] <= (ctrl_q[i] & ~wrMask) | (wdata & wrMask);
      end
   end

endmodule

// File: tb/tb_mmr_regbank.sv
// Directed bench for mmr_regbank: writes, bursts, decode errors, strobes and mid-burst reset.
// Expected register contents are tracked by hand in expCtrl.
module tb_mmr_regbank;
   localparam int ID_W = 12;
   localparam int RW_COUNT = 16;
   localparam int RO_COUNT = 8;

   logic fclk0 = 1'b0;
   logic fclk0_rst_n;
   logic [ID_W-1:0] awid, wid, bid, arid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [3:0] awlen, arlen, wstrb;
   logic [1:0] awburst, arburst, bresp, rresp;
   logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rlast, rvalid, rready;
   logic [RW_COUNT*32-1:0] ctrl;
   logic [RW_COUNT-1:0] ctrl_wstb;
   logic [RO_COUNT*32-1:0] status;

   int checks = 0;
   int failures = 0;
   logic [31:0] expCtrl [RW_COUNT];
   logic [31:0] rdVal;
   logic [1:0]  rdResp, bRespObs;
   logic        rdLast;
   logic [ID_W-1:0] bIdObs;

   always #5 fclk0 = ~fclk0;

   mmr_regbank dut (
      .fclk0(fclk0), .fclk0_rst_n(fclk0_rst_n),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .ctrl(ctrl), .ctrl_wstb(ctrl_wstb), .status(status)
   );

   function automatic logic [RW_COUNT*32-1:0] packCtrl();
      logic [RW_COUNT*32-1:0] v;
      for (int i = 0; i < RW_COUNT; i++) v[32*i +: 32] = expCtrl[i];
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge fclk0);
      #1;
   endtask

   task automatic sendAw(input logic [ID_W-1:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
      int n = 0;
      awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
      while (!awready && n < 50) begin tick(); n++; end
      checkOutput("awready", awready, 1'b1);
      tick();
      awvalid = 1'b0;
   endtask

   task automatic sendW(input logic [ID_W-1:0] id, input logic [31:0] data,
                        input logic [3:0] strb, input logic last);
      int n = 0;
      wid = id; wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
      while (!wready && n < 50) begin tick(); n++; end
      checkOutput("wready", wready, 1'b1);
      tick();
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic waitB(output logic [1:0] resp, output logic [ID_W-1:0] id);
      int n = 0;
      bready = 1'b1;
      while (!bvalid && n < 50) begin tick(); n++; end
      checkOutput("bvalid", bvalid, 1'b1);
      resp = bresp; id = bid;
      tick();
      bready = 1'b0;
   endtask

   task automatic sendAr(input logic [ID_W-1:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
      int n = 0;
      arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
      while (!arready && n < 50) begin tick(); n++; end
      checkOutput("arready", arready, 1'b1);
      tick();
      arvalid = 1'b0;
   endtask

   task automatic recvR(output logic [31:0] data, output logic [1:0] resp, output logic last);
      int n = 0;
      rready = 1'b1;
      while (!rvalid && n < 50) begin tick(); n++; end
      checkOutput("rvalid", rvalid, 1'b1);
      data = rdata; resp = rresp; last = rlast;
      tick();
      rready = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                input logic [ID_W-1:0] id, output logic [1:0] resp,
                                output logic [ID_W-1:0] idObs);
      sendAw(id, addr, 4'd0, 2'b01);
      sendW(id, data, strb, 1'b1);
      waitB(resp, idObs);
   endtask

   initial begin
      fclk0_rst_n = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
      wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
      status = '0;
      status[32*1 +: 32] = 32'h1234_5678;
      status[32*7 +: 32] = 32'hCAFE_0007;
      for (int i = 0; i < RW_COUNT; i++) expCtrl[i] = '0;
      tick(); tick(); tick();

      checkOutput("rst_awready", awready, 1'b0);
      checkOutput("rst_arready", arready, 1'b0);
      checkOutput("rst_bvalid", bvalid, 1'b0);
      checkOutput("rst_rvalid", rvalid, 1'b0);
      checkOutput("rst_bresp_rresp", {bresp, rresp}, 4'b0);
      checkOutput("rst_ctrl", ctrl, packCtrl());
      checkOutput("rst_wstb", ctrl_wstb, 16'h0);
      fclk0_rst_n = 1'b1;
      tick(); tick();

      // Single write to 0x08.
      sendAw(12'h5A3, 32'h08, 4'd0, 2'b01);
      sendW(12'h5A3, 32'hA5A5_0001, 4'hF, 1'b1);
      expCtrl[2] = 32'hA5A5_0001;
      checkOutput("t1_ctrl", ctrl, packCtrl());
      checkOutput("t1_wstb_pulse", ctrl_wstb, 16'h0004);
      tick();
      checkOutput("t1_wstb_clear", ctrl_wstb, 16'h0000);
      waitB(bRespObs, bIdObs);
      checkOutput("t1_bresp", bRespObs, 2'b00);
      checkOutput("t1_bid", bIdObs, 12'h5A3);

      // INCR write burst fills ctrl[0..3], then read it back with a stall on beat 2.
      sendAw(12'h001, 32'h00, 4'd3, 2'b01);
      for (int i = 0; i < 4; i++) begin
         expCtrl[i] = 32'h1111_0000 * (i + 1) + i;
         sendW(12'h001, expCtrl[i], 4'hF, i == 3);
      end
      waitB(bRespObs, bIdObs);
      checkOutput("t2_burst_bresp", bRespObs, 2'b00);
      checkOutput("t2_burst_ctrl", ctrl, packCtrl());

      sendAr(12'h002, 32'h00, 4'd3, 2'b01);
      recvR(rdVal, rdResp, rdLast);
      checkOutput("t2_beat1", {rdVal, rdResp, rdLast}, {expCtrl[0], 2'b00, 1'b0});
      for (int i = 0; i < 5; i++) tick();
      checkOutput("t2_stall_hold", {rvalid, rdata, rresp, rlast}, {1'b1, expCtrl[1], 2'b00, 1'b0});
      recvR(rdVal, rdResp, rdLast);
      checkOutput("t2_beat2", {rdVal, rdResp, rdLast}, {expCtrl[1], 2'b00, 1'b0});
      recvR(rdVal, rdResp, rdLast);
      checkOutput("t2_beat3", {rdVal, rdResp, rdLast}, {expCtrl[2], 2'b00, 1'b0});
      recvR(rdVal, rdResp, rdLast);
      checkOutput("t2_beat4", {rdVal, rdResp, rdLast}, {expCtrl[3], 2'b00, 1'b1});
      tick();
      checkOutput("t2_rvalid_done", rvalid, 1'b0);

      // Status word 1 lives at word RW_COUNT+1 = byte 0x44.
      sendAr(12'h003, 32'h44, 4'd0, 2'b01);
      recvR(rdVal, rdResp, rdLast);
      checkOutput("t3_status_read", {rdVal, rdResp, rdLast}, {32'h1234_5678, 2'b00, 1'b1});
      applyStimulus(32'h44, 32'h0000_FFFF, 4'hF, 12'h004, bRespObs, bIdObs);
      checkOutput("t3_status_wr_bresp", bRespObs, 2'b00);
      checkOutput("t3_status_wr_ctrl", ctrl, packCtrl());

      // Out-of-range word 0x3FF.
      applyStimulus(32'hFFC, 32'hDEAD_BEEF, 4'hF, 12'h005, bRespObs, bIdObs);
      checkOutput("t4_oor_bresp", bRespObs, 2'b10);
      checkOutput("t4_oor_ctrl", ctrl, packCtrl());
      sendAr(12'h006, 32'hFFC, 4'd0, 2'b01);
      recvR(rdVal, rdResp, rdLast);
      checkOutput("t4_oor_read", {rdVal, rdResp}, {32'h0, 2'b10});

      // A beat whose WID differs from AWID is dropped with SLVERR.
      sendAw(12'h00A, 32'h10, 4'd0, 2'b01);
      sendW(12'h00B, 32'h7777_7777, 4'hF, 1'b1);
      waitB(bRespObs, bIdObs);
      checkOutput("wid_mismatch_bresp", {bRespObs, bIdObs}, {2'b10, 12'h00A});
      checkOutput("wid_mismatch_ctrl", ctrl, packCtrl());

      // FIXED burst keeps hitting reg 5; the last beat wins.
      sendAw(12'h00C, 32'h14, 4'd1, 2'b00);
      sendW(12'h00C, 32'hAAAA_0005, 4'hF, 1'b0);
      sendW(12'h00C, 32'hBBBB_0005, 4'hF, 1'b1);
      expCtrl[5] = 32'hBBBB_0005;
      waitB(bRespObs, bIdObs);
      checkOutput("fixed_bresp", bRespObs, 2'b00);
      checkOutput("fixed_ctrl", ctrl, packCtrl());

      // Read burst starting at the last status word runs off the bank on beat 2.
      sendAr(12'h00D, 32'h5C, 4'd1, 2'b01);
      recvR(rdVal, rdResp, rdLast);
      checkOutput("edge_beat1", {rdVal, rdResp, rdLast}, {32'hCAFE_0007, 2'b00, 1'b0});
      recvR(rdVal, rdResp, rdLast);
      checkOutput("edge_beat2", {rdVal, rdResp, rdLast}, {32'h0, 2'b10, 1'b1});

      // Reset asserted while beat 2 of a 4-beat write is offered.
      sendAw(12'h00E, 32'h20, 4'd3, 2'b01);
      sendW(12'h00E, 32'h9999_0008, 4'hF, 1'b0);
      wdata = 32'h9999_0009; wvalid = 1'b1;
      fclk0_rst_n = 1'b0;
      tick(); tick();
      for (int i = 0; i < RW_COUNT; i++) expCtrl[i] = '0;
      checkOutput("t6_rst_ctrl", ctrl, packCtrl());
      checkOutput("t6_rst_bvalid", bvalid, 1'b0);
      checkOutput("t6_rst_wstb", ctrl_wstb, 16'h0);
      wvalid = 1'b0;
      fclk0_rst_n = 1'b1;
      tick(); tick(); tick();
      checkOutput("t6_post_bvalid", bvalid, 1'b0);
      applyStimulus(32'h0C, 32'h0BAD_F00D, 4'hF, 12'h0F0, bRespObs, bIdObs);
      expCtrl[3] = 32'h0BAD_F00D;
      checkOutput("t6_new_write_b", {bRespObs, bIdObs}, {2'b00, 12'h0F0});
      checkOutput("t6_new_write_ctrl", ctrl, packCtrl());

      // Partial strobe onto reg 0, which is zero after the reset above.
      applyStimulus(32'h00, 32'hFFFF_FFFF, 4'b0010, 12'h0F1, bRespObs, bIdObs);
`ifdef MMR_REGBANK_WSTRB_EN
      expCtrl[0] = 32'h0000_FF00;
`else
      expCtrl[0] = 32'hFFFF_FFFF;
`endif
      checkOutput("t5_strobe_bresp", bRespObs, 2'b00);
      checkOutput("t5_strobe_ctrl", ctrl, packCtrl());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
